// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage.
// Holds the fetch PC, issues single-outstanding word fetches over a
// req/gnt/rvalid handshake, buffers responses in a 2-entry FIFO and presents
// {PC, IR} to decode. Jump/branch redirects flush the FIFO and any
// in-flight fetch, then restart fetching at iBR_PC + iBR_OFS.
//
// Build option IFETCH_MISALIGN_EN:
//   defined   - a target with bits [1:0] != 0 raises oMISALIGN and parks the
//               fetcher in HOLD until the next redirect or reset.
//   undefined - no oMISALIGN port; the target's low two bits are cleared.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic        oIMEM_REQ,
  output logic [31:0] oIMEM_ADDR,
  input  logic        iIMEM_GNT,
  input  logic        iIMEM_RVALID,
  input  logic [31:0] iIMEM_RDATA,
  input  logic        iBR_VALID,
  input  logic [31:0] iBR_PC,
  input  logic [31:0] iBR_OFS,
  output logic        oVALID,
  input  logic        iREADY,
  output logic [31:0] oIR,
  output logic [31:0] oPC
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic        oMISALIGN
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetchState_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetchEntry_t;

  fetchState_t state, stateNext;

  // 2-entry instruction FIFO
  fetchEntry_t fifoMem [2];
  logic [1:0]  count, countNext;
  logic        rdPtr, wrPtr;

  logic [31:0] fetchPc;      // next address to request
  logic [31:0] inflightPc;   // address of the outstanding request
  logic [31:0] pcHold;       // last PC shown while oVALID was high
  logic        misalignQ;    // fetch parked on a misaligned target

  logic [31:0] brTarget, targetPc;
  logic        tgtMisalign;
  logic        qValid, grant, push, pop, inflightAfter;

  // Redirect target; wraps modulo 2^32. The stored fetch PC is always
  // word aligned so oIMEM_ADDR[1:0] stays zero even when parked.
  assign brTarget = iBR_PC + iBR_OFS;
  assign targetPc = brTarget & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_EN
  assign tgtMisalign = |brTarget[1:0];
  assign oMISALIGN   = misalignQ;
`else
  assign tgtMisalign = 1'b0;
`endif

  assign qValid = (count != 2'd0);
  assign grant  = (state == REQ) && iIMEM_GNT;
  // A redirect overrides any same-cycle push or pop: the FIFO is flushed.
  assign push   = (state == WAIT) && iIMEM_RVALID && !iBR_VALID;
  assign pop    = qValid && iREADY && !iBR_VALID;

  // A request is still in flight after this edge if it is granted now, or
  // if we were already waiting and the response has not shown up yet. A
  // redirect only needs DROP when something stale is still coming back.
  assign inflightAfter = grant ||
                         (((state == WAIT) || (state == DROP)) && !iIMEM_RVALID);

  assign oIMEM_ADDR = fetchPc;
  assign oVALID     = qValid;
  assign oIR        = qValid ? fifoMem[rdPtr].ir : NOP_IR;
  assign oPC        = qValid ? fifoMem[rdPtr].pc : pcHold;

  // FIFO occupancy after this cycle's push/pop/flush
  always_comb begin
    countNext = count;
    if (iBR_VALID)         countNext = 2'd0;
    else if (push && !pop) countNext = count + 2'd1;
    else if (pop && !push) countNext = count - 2'd1;
  end

  // Fetch FSM: next state and request strobe
  always_comb begin
    stateNext = state;
    oIMEM_REQ = 1'b0;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        oIMEM_REQ = 1'b1;
        if (iIMEM_GNT) stateNext = WAIT;
      end
      // Nothing is outstanding once the response lands, so room is just
      // the post-push FIFO count.
      WAIT: if (iIMEM_RVALID) stateNext = (countNext != 2'd2) ? REQ : HOLD;
      HOLD: if (!misalignQ && (count != 2'd2)) stateNext = REQ;
      DROP: if (iIMEM_RVALID) stateNext = misalignQ ? HOLD : REQ;
      default: stateNext = IDLE;
    endcase
    if (iBR_VALID) begin
      if (inflightAfter)    stateNext = DROP;
      else if (tgtMisalign) stateNext = HOLD;
      else                  stateNext = REQ;
    end
  end

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  // Fetch PC advance on grant, reload on redirect; remember in-flight address
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fetchPc    <= RESET_PC;
      inflightPc <= RESET_PC;
    end else begin
      if (grant)          inflightPc <= fetchPc;
      if (iBR_VALID)      fetchPc    <= targetPc;
      else if (grant)     fetchPc    <= fetchPc + 32'd4;
    end
  end

  // FIFO pointers, occupancy and held output PC
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count  <= 2'd0;
      rdPtr  <= 1'b0;
      wrPtr  <= 1'b0;
      pcHold <= RESET_PC;
    end else begin
      count <= countNext;
      if (qValid) pcHold <= fifoMem[rdPtr].pc;
      if (iBR_VALID) begin
        rdPtr <= 1'b0;
        wrPtr <= 1'b0;
      end else begin
        if (push) wrPtr <= ~wrPtr;
        if (pop)  rdPtr <= ~rdPtr;
      end
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge iCLK) begin
    if (push) fifoMem[wrPtr] <= '{pc: inflightPc, ir: iIMEM_RDATA};
  end

  // Misaligned-target flag, re-evaluated on every redirect
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)        misalignQ <= 1'b0;
    else if (iBR_VALID) misalignQ <= tgtMisalign;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch with a
// scoreboard. Expected PCs are queued by the stimulus; a monitor pops and
// compares on every accepted instruction. The memory model returns
// addr ^ 32'hDEAD_0000 so IR and PC are distinguishable.
module tb_instruction_fetch;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b1;
  logic        oIMEM_REQ;
  logic [31:0] oIMEM_ADDR;
  logic        iIMEM_GNT = 1'b1;
  logic        iIMEM_RVALID = 1'b0;
  logic [31:0] iIMEM_RDATA = 32'h0;
  logic        iBR_VALID = 1'b0;
  logic [31:0] iBR_PC = 32'h0;
  logic [31:0] iBR_OFS = 32'h0;
  logic        oVALID;
  logic        iREADY = 1'b1;
  logic [31:0] oIR;
  logic [31:0] oPC;
`ifdef IFETCH_MISALIGN_EN
  logic        oMISALIGN;
`endif

  instruction_fetch dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .oIMEM_REQ   (oIMEM_REQ),
    .oIMEM_ADDR  (oIMEM_ADDR),
    .iIMEM_GNT   (iIMEM_GNT),
    .iIMEM_RVALID(iIMEM_RVALID),
    .iIMEM_RDATA (iIMEM_RDATA),
    .iBR_VALID   (iBR_VALID),
    .iBR_PC      (iBR_PC),
    .iBR_OFS     (iBR_OFS),
    .oVALID      (oVALID),
    .iREADY      (iREADY),
    .oIR         (oIR),
    .oPC         (oPC)
`ifdef IFETCH_MISALIGN_EN
    ,
    .oMISALIGN   (oMISALIGN)
`endif
  );

  always #5 iCLK = ~iCLK;

  int          nCmp = 0;
  int          nBad = 0;
  int          memLat = 1;
  int          grantCnt = 0;
  logic [31:0] expQ [$];

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // One-cycle redirect pulse; called and returns at posedge+1
  task automatic redirect(input logic [31:0] pc, input logic [31:0] ofs);
    iBR_VALID = 1'b1;
    iBR_PC    = pc;
    iBR_OFS   = ofs;
    tick();
    iBR_VALID = 1'b0;
  endtask

  // Accept until every queued expectation is consumed, then stall downstream
  // and let the fetcher fill its FIFO and park.
  task automatic drain();
    int n;
    n = 0;
    iREADY = 1'b1;
    while (expQ.size() != 0 && n < 80) begin
      @(posedge iCLK);
      n++;
    end
    #1;
    iREADY = 1'b0;
    chk("drain_left", expQ.size(), 0);
    expQ.delete();
    repeat (10) tick();
  endtask

  // Memory model: in-order, single outstanding, latency memLat cycles
  initial begin : memModel
    logic        fire;
    logic [31:0] fireAddr;
    logic        pend;
    logic [31:0] pendAddr;
    int          left;
    pend = 1'b0;
    pendAddr = 32'h0;
    left = 0;
    forever begin
      @(negedge iCLK);
      fire     = oIMEM_REQ && iIMEM_GNT;
      fireAddr = oIMEM_ADDR;
      @(posedge iCLK);
      #1;
      iIMEM_RVALID = 1'b0;
      if (fire) begin
        grantCnt++;
        pend     = 1'b1;
        pendAddr = fireAddr;
        left     = memLat;
      end
      if (pend) begin
        left--;
        if (left == 0) begin
          pend         = 1'b0;
          iIMEM_RVALID = 1'b1;
          iIMEM_RDATA  = memData(pendAddr);
        end
      end
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge iCLK);
      if (iRST_N && oVALID && iREADY) begin
        if (expQ.size() == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL unexpected_pop: got pc %h expected none", oPC);
        end else begin
          e = expQ.pop_front();
          chk("pop_pc", oPC, e);
          chk("pop_ir", oIR, memData(e));
        end
      end
    end
  end

  initial begin : main
    int g0;
    #1 iRST_N = 1'b0;
    repeat (3) tick();
    chk("rst_req",   oIMEM_REQ,  0);
    chk("rst_addr",  oIMEM_ADDR, 32'h0);
    chk("rst_valid", oVALID,     0);
    chk("rst_ir",    oIR,        32'h0000_0013);
    chk("rst_pc",    oPC,        32'h0);
`ifdef IFETCH_MISALIGN_EN
    chk("rst_mis",   oMISALIGN,  0);
`endif

    // Streaming with a 1-cycle memory, then stall and fill
    expQ = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    @(negedge iCLK);
    iRST_N = 1'b1;
    tick();
    @(negedge iCLK);
    chk("first_req",  oIMEM_REQ, 1);
    chk("first_addr", oIMEM_ADDR, 32'h0);
    tick(); @(negedge iCLK);
    chk("lat_n1_valid", oVALID, 0);
    tick(); @(negedge iCLK);
    chk("lat_n2_valid", oVALID, 1);
    chk("lat_n2_pc",    oPC, 32'h0);
    tick(); @(negedge iCLK);
    chk("tput_n3_valid", oVALID, 0);
    tick(); @(negedge iCLK);
    chk("tput_n4_valid", oVALID, 1);
    chk("tput_n4_pc",    oPC, 32'h4);
    tick();
    drain();

    // Stalled: two entries queued, no request, fetch PC past both
    chk("full_req",   oIMEM_REQ, 0);
    chk("full_valid", oVALID, 1);
    chk("full_pc",    oPC, 32'h18);
    chk("full_addr",  oIMEM_ADDR, 32'h20);
    expQ = '{32'h18, 32'h1C, 32'h20};
    drain();

    // Redirect with a full FIFO: 0x100 + (-16) = 0xF0
    redirect(32'h100, 32'hFFFF_FFF0);
    @(negedge iCLK);
    chk("flush_valid", oVALID, 0);
    chk("flush_ir",    oIR, 32'h0000_0013);
    chk("flush_pc",    oPC, 32'h24);
    chk("flush_req",   oIMEM_REQ, 1);
    chk("flush_addr",  oIMEM_ADDR, 32'hF0);
    expQ = '{32'hF0, 32'hF4};
    tick();
    drain();

    // Redirect during WAIT with a 3-cycle memory
    memLat = 3;
    redirect(32'h200, 32'h0);
    tick();
    redirect(32'h280, 32'h80);
    @(negedge iCLK);
    chk("drop_req",  oIMEM_REQ, 0);
    chk("drop_addr", oIMEM_ADDR, 32'h300);
    tick(); @(negedge iCLK);
    chk("drop_stale_req", oIMEM_REQ, 0);
    tick(); @(negedge iCLK);
    chk("drop_restart_req",  oIMEM_REQ, 1);
    chk("drop_restart_addr", oIMEM_ADDR, 32'h300);
    expQ = '{32'h300, 32'h304};
    tick();
    drain();

    // Asynchronous reset in the middle of WAIT
    redirect(32'h400, 32'h0);
    tick();
    #1 iRST_N = 1'b0;
    #1;
    chk("arst_req",   oIMEM_REQ, 0);
    chk("arst_addr",  oIMEM_ADDR, 32'h0);
    chk("arst_valid", oVALID, 0);
    chk("arst_ir",    oIR, 32'h0000_0013);
    chk("arst_pc",    oPC, 32'h0);
    memLat = 1;
    tick();
    iRST_N = 1'b1;
    @(negedge iCLK);
    chk("arst_idle_req", oIMEM_REQ, 0);
    tick(); @(negedge iCLK);
    chk("arst_rel_req",  oIMEM_REQ, 1);
    chk("arst_rel_addr", oIMEM_ADDR, 32'h0);
    expQ = '{32'h0, 32'h4};
    tick();
    drain();

    // Misaligned target 0x102
    redirect(32'h100, 32'h2);
    @(negedge iCLK);
`ifdef IFETCH_MISALIGN_EN
    chk("mis_flag", oMISALIGN, 1);
    chk("mis_req",  oIMEM_REQ, 0);
    g0 = grantCnt;
    repeat (6) @(negedge iCLK);
    chk("mis_grants", grantCnt, g0);
    chk("mis_req_late", oIMEM_REQ, 0);
    chk("mis_valid", oVALID, 0);
    tick();
    redirect(32'h200, 32'h0);
    @(negedge iCLK);
    chk("mis_clr_flag", oMISALIGN, 0);
    chk("mis_clr_req",  oIMEM_REQ, 1);
    chk("mis_clr_addr", oIMEM_ADDR, 32'h200);
    expQ = '{32'h200, 32'h204};
`else
    g0 = grantCnt;
    chk("mis_req",  oIMEM_REQ, 1);
    chk("mis_addr", oIMEM_ADDR, 32'h100);
    expQ = '{32'h100, 32'h104};
`endif
    tick();
    drain();

    // Target wraps past 2^32: 0xFFFF_FFF0 + 0x20 = 0x10
    redirect(32'hFFFF_FFF0, 32'h20);
    @(negedge iCLK);
    chk("wrap_req",  oIMEM_REQ, 1);
    chk("wrap_addr", oIMEM_ADDR, 32'h10);
    expQ = '{32'h10, 32'h14};
    tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
